// File: rtl/sub_share_pkg.sv
// Shared types and constants for the SUB-unit sharing arbiter.
package sub_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int MAX_NREQ = 8;

    // Next requester index after idx, wrapping back to 0 past the last requester.
    function automatic int wrapInc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sub_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr, with wrap.
module rr_pick
    import sub_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] win_o,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    // Scan ptr, ptr+1, ... mod NREQ and keep only the first requester found.
    always_comb begin
        int pos;
        win_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr_i) + k) % NREQ;
            if (!valid_o && req_i[pos]) begin
                win_o[pos] = 1'b1;
                idx_o      = PW'(pos);
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sub_share_arbiter.sv
// Shares one fixed-latency SUB unit among NREQ requesters, one transaction at a time.
module sub_share_arbiter
    import sub_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] in_bit_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            sub_in_o,
    output logic            sub_vld_o,
    input  logic            sub_out_i,
    output logic [NREQ-1:0] rsp_vld_o,
    output logic            rsp_bit_o,
    output logic            busy_o
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic            op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            sub_vld_q, sub_vld_d;
    logic            sub_in_q, sub_in_d;
    logic [NREQ-1:0] rsp_vld_q, rsp_vld_d;
    logic            rsp_bit_q, rsp_bit_d;

    logic [NREQ-1:0] pickWin;
    logic [PW-1:0]   pickIdx;
    logic            pickValid;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .win_o   (pickWin),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );

    // Sequence grant, issue, latency wait and response; every output is registered.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        sub_vld_d = 1'b0;
        sub_in_d  = 1'b0;
        rsp_vld_d = '0;
        rsp_bit_d = rsp_bit_q;
        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    gnt_d   = pickWin;
                    owner_d = pickIdx;
                    op_d    = in_bit_i[pickIdx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                sub_vld_d = 1'b1;
                sub_in_d  = op_q;
                cnt_d     = CNT_LOAD;
                ptr_d     = PW'(wrapInc(int'(owner_q), NREQ));
                state_d   = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_bit_d = sub_out_i;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                for (int i = 0; i < NREQ; i++) begin
                    rsp_vld_d[i] = (int'(owner_q) == i);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops everything, discarding any in-flight result.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            op_q      <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            sub_vld_q <= 1'b0;
            sub_in_q  <= 1'b0;
            rsp_vld_q <= '0;
            rsp_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            sub_vld_q <= sub_vld_d;
            sub_in_q  <= sub_in_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_bit_q <= rsp_bit_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign sub_in_o  = sub_in_q;
    assign sub_vld_o = sub_vld_q;
    assign rsp_vld_o = rsp_vld_q;
    assign rsp_bit_o = rsp_bit_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Self-checking bench for sub_share_arbiter: transaction-level model plus directed scenarios.
module tb_sub_share_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NREQ-1:0] req_i;
    logic [NREQ-1:0] in_bit_i;
    logic [NREQ-1:0] gnt_o;
    logic            sub_in_o;
    logic            sub_vld_o;
    logic            sub_out_i = 1'b0;
    logic [NREQ-1:0] rsp_vld_o;
    logic            rsp_bit_o;
    logic            busy_o;

    int checks   = 0;
    int failures = 0;

    sub_share_arbiter #(
        .NREQ (NREQ),
        .LAT  (LAT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_i     (req_i),
        .in_bit_i  (in_bit_i),
        .gnt_o     (gnt_o),
        .sub_in_o  (sub_in_o),
        .sub_vld_o (sub_vld_o),
        .sub_out_i (sub_out_i),
        .rsp_vld_o (rsp_vld_o),
        .rsp_bit_o (rsp_bit_o),
        .busy_o    (busy_o)
    );

    always #5 CLK = ~CLK;

    // Count one comparison and report it when the DUT value differs from the expected one.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    // Report an expired wait bound as a failed comparison.
    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] b);
        req_i    = r;
        in_bit_i = b;
    endtask

    // Advance at least one cycle, then wait (bounded) for the next grant and check it.
    task automatic waitGrant(input int expected, input string name);
        int n;
        n = 0;
        @(negedge CLK);
        while (gnt_o == '0 && n < LAT + 8) begin
            @(negedge CLK);
            n++;
        end
        if (gnt_o == '0) timeoutFail(name);
        else checkOutput(name, int'(gnt_o), expected);
    endtask

    // Wait (bounded) until the arbiter is no longer busy.
    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy_o && n < LAT + 8) begin
            @(negedge CLK);
            n++;
        end
        if (busy_o) timeoutFail(name);
    endtask

    // SUB model: identity function, result valid only on the sampling edge LAT edges after
    // the strobe; the complement is driven at all other times so a mistimed capture shows.
    logic subPend = 1'b0;
    logic subOp   = 1'b0;
    int   subAge  = 0;
    always @(negedge CLK) begin
        if (!RST) subPend = 1'b0;
        if (sub_vld_o) begin
            subPend = 1'b1;
            subOp   = sub_in_o;
            subAge  = 0;
        end else if (subPend) begin
            subAge++;
        end
        if (subPend && subAge == LAT - 1) begin
            sub_out_i = subOp;
            subPend   = 1'b0;
        end else begin
            sub_out_i = ~subOp;
        end
    end

    // Transaction model: mT counts cycles since the grant became visible (LAT+3 = idle).
    int              mT     = LAT + 3;
    int              mPtr   = 0;
    int              mOwner = 0;
    logic            mOp    = 1'b0;
    logic            mFound;
    logic [NREQ-1:0] mOh;
    logic [NREQ-1:0] mExpGnt;
    logic [NREQ-1:0] mExpRsp;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mT     = LAT + 3;
            mPtr   = 0;
            mOwner = 0;
            mOp    = 1'b0;
        end else if (mT <= LAT + 1) begin
            mT++;
        end else if (req_i != '0) begin
            mFound = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!mFound && req_i[(mPtr + k) % NREQ]) begin
                    mOwner = (mPtr + k) % NREQ;
                    mFound = 1'b1;
                end
            end
            mOp  = in_bit_i[mOwner];
            mPtr = (mOwner + 1) % NREQ;
            mT   = 0;
        end else begin
            mT = LAT + 3;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge CLK) begin
        mOh          = '0;
        mOh[mOwner]  = 1'b1;
        mExpGnt      = (mT == 0) ? mOh : '0;
        mExpRsp      = (mT == LAT + 2) ? mOh : '0;
        checkOutput("model gnt", int'(gnt_o), int'(mExpGnt));
        checkOutput("model sub_vld", int'(sub_vld_o), int'(mT == 1));
        if (mT == 1) checkOutput("model sub_in", int'(sub_in_o), int'(mOp));
        checkOutput("model rsp_vld", int'(rsp_vld_o), int'(mExpRsp));
        if (mT == LAT + 2) checkOutput("model rsp_bit", int'(rsp_bit_o), int'(mOp));
        checkOutput("model busy", int'(busy_o), int'(mT <= LAT + 1));
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int vldCount;
    int extraGnt;
    int rspCount;

    initial begin
        RST = 1'b0;
        applyStimulus('b1111, 'b1010);
        repeat (3) @(negedge CLK);

        // Reset holds everything quiet even with all requests up.
        checkOutput("reset gnt", int'(gnt_o), 'b0000);
        checkOutput("reset sub_vld", int'(sub_vld_o), 0);
        checkOutput("reset rsp_vld", int'(rsp_vld_o), 'b0000);
        checkOutput("reset busy", int'(busy_o), 0);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("release gnt", int'(gnt_o), 'b0001);

        // Fairness with all requests held: 0,1,2,3,0.
        waitGrant('b0010, "fair gnt 1");
        waitGrant('b0100, "fair gnt 2");
        waitGrant('b1000, "fair gnt 3");
        waitGrant('b0001, "fair gnt 0 again");
        applyStimulus('b0000, 'b1010);
        waitIdle("fair idle");
        @(negedge CLK);

        // Single requester 2 with operand 1.
        applyStimulus('b0100, 'b0100);
        @(negedge CLK);
        checkOutput("single gnt", int'(gnt_o), 'b0100);
        applyStimulus('b0000, 'b0100);
        @(negedge CLK);
        checkOutput("single sub_vld", int'(sub_vld_o), 1);
        checkOutput("single sub_in", int'(sub_in_o), 1);
        repeat (LAT) @(negedge CLK);
        checkOutput("single rsp_vld early", int'(rsp_vld_o), 'b0000);
        @(negedge CLK);
        checkOutput("single rsp_vld", int'(rsp_vld_o), 'b0100);
        checkOutput("single rsp_bit", int'(rsp_bit_o), 1);
        @(negedge CLK);
        checkOutput("single rsp_vld after", int'(rsp_vld_o), 'b0000);

        // Pointer now 3: requester 3 first, then wrap to requester 0.
        applyStimulus('b1001, 'b0001);
        @(negedge CLK);
        checkOutput("wrap gnt 3", int'(gnt_o), 'b1000);
        applyStimulus('b0001, 'b0001);
        waitGrant('b0001, "wrap gnt 0");
        applyStimulus('b0000, 'b0001);
        waitIdle("wrap idle");
        @(negedge CLK);

        // Requests toggling while the transaction is in flight are ignored.
        applyStimulus('b0010, 'b0010);
        @(negedge CLK);
        checkOutput("midflight gnt", int'(gnt_o), 'b0010);
        applyStimulus('b0000, 'b0010);
        vldCount = 0;
        extraGnt = 0;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge CLK);
            if (sub_vld_o) vldCount++;
            if (gnt_o != '0) extraGnt++;
            if (i <= LAT) applyStimulus((i % 2 == 1) ? 4'b1111 : 4'b0101, 'b1111);
            else applyStimulus('b0000, 'b0000);
        end
        @(negedge CLK);
        checkOutput("midflight rsp_vld", int'(rsp_vld_o), 'b0010);
        checkOutput("midflight sub_vld count", vldCount, 1);
        checkOutput("midflight extra gnt", extraGnt, 0);
        @(negedge CLK);

        // Reset while waiting with cnt=1: drops at once, no response afterwards.
        applyStimulus('b0100, 'b0100);
        @(negedge CLK);
        checkOutput("reset-wait gnt", int'(gnt_o), 'b0100);
        applyStimulus('b0000, 'b0100);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        checkOutput("reset-wait busy", int'(busy_o), 0);
        checkOutput("reset-wait sub_vld", int'(sub_vld_o), 0);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        rspCount = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(negedge CLK);
            if (rsp_vld_o != '0) rspCount++;
        end
        checkOutput("reset-wait no rsp", rspCount, 0);

        // Pointer returned to 0 by reset: requesters 1 and 3 -> 1 wins.
        applyStimulus('b1010, 'b1010);
        @(negedge CLK);
        checkOutput("post-reset gnt", int'(gnt_o), 'b0010);
        applyStimulus('b0000, 'b1010);
        waitIdle("final idle");
        @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
